// File: rtl/sm_trace_fifo_if.sv
// Trace capture bundle: CPU retire stream in, drained trace out, plus status.
// SM_TRACE_TRIGGER_EN adds trig_pc/armed for PC-triggered capture.
interface sm_trace_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned OVF_W      = 8
);
    logic                  trc_valid;
    logic [31:0]           trc_pc;
    logic [31:0]           trc_instr;
    logic                  freeze;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_pc;
    logic [31:0]           out_instr;
    logic [CYC_W-1:0]      out_cyc;
    logic [DEPTH_LOG2:0]   level;
    logic [OVF_W-1:0]      ovf_cnt;
`ifdef SM_TRACE_TRIGGER_EN
    logic [31:0]           trig_pc;
    logic                  armed;

    modport master (
        output trc_valid, trc_pc, trc_instr, freeze, out_ready, trig_pc,
        input  out_valid, out_pc, out_instr, out_cyc, level, ovf_cnt, armed
    );
    modport slave (
        input  trc_valid, trc_pc, trc_instr, freeze, out_ready, trig_pc,
        output out_valid, out_pc, out_instr, out_cyc, level, ovf_cnt, armed
    );
`else
    modport master (
        output trc_valid, trc_pc, trc_instr, freeze, out_ready,
        input  out_valid, out_pc, out_instr, out_cyc, level, ovf_cnt
    );
    modport slave (
        input  trc_valid, trc_pc, trc_instr, freeze, out_ready,
        output out_valid, out_pc, out_instr, out_cyc, level, ovf_cnt
    );
`endif
endinterface

// File: rtl/sm_trace_fifo.sv
// Time-stamped execution-trace FIFO behind sm_cpu, drained over valid/ready.
// Define SM_TRACE_TRIGGER_EN to hold off capture until trc_pc matches trig_pc.
module sm_trace_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned OVF_W      = 8
) (
    input logic             clk_i,
    input logic             rst_i,
    sm_trace_fifo_if.slave  trc_if
);
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

    logic [31:0]      pc_mem    [Depth];
    logic [31:0]      instr_mem [Depth];
    logic [CYC_W-1:0] cyc_mem   [Depth];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [OVF_W-1:0]      ovf_q, ovf_d;

    logic full, out_valid, pop, cand, push, drop, arm_ok;

`ifdef SM_TRACE_TRIGGER_EN
    logic armed_q, armed_d;
    logic pc_hit;

    // The matching entry itself is captured, so the hit qualifies this cycle's push.
    assign pc_hit       = (trc_if.trc_pc == trc_if.trig_pc);
    assign arm_ok       = armed_q | pc_hit;
    assign armed_d      = armed_q | (trc_if.trc_valid & ~trc_if.freeze & pc_hit);
    assign trc_if.armed = armed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`else
    assign arm_ok = 1'b1;
`endif

    always_comb begin
        full      = (level_q == LevelFull);
        out_valid = (level_q != '0);
        pop       = out_valid & trc_if.out_ready;
        cand      = trc_if.trc_valid & ~trc_if.freeze & arm_ok;
        push      = cand & (~full | pop);
        drop      = cand & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cyc_d    = cyc_q + CYC_W'(1);
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + (DEPTH_LOG2)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (DEPTH_LOG2)'(1);

        unique case ({push, pop})
            2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
            default: level_d = level_q;
        endcase

        if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cyc_q    <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cyc_q    <= cyc_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            pc_mem[wr_ptr_q]    <= trc_if.trc_pc;
            instr_mem[wr_ptr_q] <= trc_if.trc_instr;
            cyc_mem[wr_ptr_q]   <= cyc_q;
        end
    end

    assign trc_if.out_valid = out_valid;
    assign trc_if.out_pc    = pc_mem[rd_ptr_q];
    assign trc_if.out_instr = instr_mem[rd_ptr_q];
    assign trc_if.out_cyc   = cyc_mem[rd_ptr_q];
    assign trc_if.level     = level_q;
    assign trc_if.ovf_cnt   = ovf_q;
endmodule

// File: tb/tb_sm_trace_fifo.sv
// Randomised and directed bench for sm_trace_fifo against a queue-based trace model.
// Honours SM_TRACE_TRIGGER_EN for the trigger scenario.
module tb_sm_trace_fifo;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned CYC_W      = 16;
    localparam int unsigned OVF_W      = 8;
    localparam int unsigned Depth      = 16;
`ifdef SM_TRACE_TRIGGER_EN
    localparam bit TrigOn = 1'b1;
`else
    localparam bit TrigOn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] cyc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        valid_v = 1'b0;
    logic [31:0] pc_v    = '0;
    logic [31:0] instr_v = '0;
    logic        freeze_v = 1'b0;
    logic        ready_v  = 1'b0;
    logic [31:0] trig_v   = 32'h1000;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ent_t mq[$];
    int   m_cyc   = 0;
    int   m_ovf   = 0;
    bit   m_armed = !TrigOn;

    always #5 clk = ~clk;

    sm_trace_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2), .CYC_W(CYC_W), .OVF_W(OVF_W)) bus ();

    assign bus.trc_valid = valid_v;
    assign bus.trc_pc    = pc_v;
    assign bus.trc_instr = instr_v;
    assign bus.freeze    = freeze_v;
    assign bus.out_ready = ready_v;
`ifdef SM_TRACE_TRIGGER_EN
    assign bus.trig_pc   = trig_v;
`endif

    sm_trace_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .CYC_W(CYC_W), .OVF_W(OVF_W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .trc_if (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare against the model at negedge, then advance the model across posedge.
    task automatic cycle();
        bit   cand;
        bit   full;
        bit   pop;
        ent_t e;
        @(negedge clk);
        if (chk_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            chk("level", 64'(bus.level), 64'(mq.size()));
            chk("ovf_cnt", 64'(bus.ovf_cnt), 64'(m_ovf));
`ifdef SM_TRACE_TRIGGER_EN
            chk("armed", 64'(bus.armed), 64'(m_armed));
`endif
            if (mq.size() != 0) begin
                chk("out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
                chk("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
                chk("out_cyc", 64'(bus.out_cyc), 64'(mq[0].cyc));
            end
        end
        if (rst) begin
            mq.delete();
            m_cyc   = 0;
            m_ovf   = 0;
            m_armed = !TrigOn;
        end else begin
            cand = valid_v && !freeze_v && (m_armed || (TrigOn && pc_v == trig_v));
            full = (mq.size() == Depth);
            pop  = (mq.size() != 0) && ready_v;
            if (TrigOn && valid_v && !freeze_v && pc_v == trig_v) m_armed = 1'b1;
            if (pop) void'(mq.pop_front());
            if (cand && (!full || pop)) begin
                e.pc    = pc_v;
                e.instr = instr_v;
                e.cyc   = 16'(m_cyc);
                mq.push_back(e);
            end else if (cand && m_ovf < 255) begin
                m_ovf++;
            end
            m_cyc = (m_cyc + 1) % 65536;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1: reset held two clocks with trc_valid asserted.
        rst = 1'b1; valid_v = 1'b1; pc_v = 32'h1000; instr_v = 32'hdead_beef;
        cycle();
        chk_en = 1'b1;
        cycle();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level", 64'(bus.level), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_cnt), 64'd0);
        rst = 1'b0;
        cycle();
        chk("first_stamp", 64'(bus.out_cyc), 64'd0);
        valid_v = 1'b0; ready_v = 1'b1;
        repeat (2) cycle();

        // T2: back-to-back stream with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            valid_v = 1'b1; pc_v = 32'(i); instr_v = 32'(i) + 32'h2402_0000;
            cycle();
        end
        valid_v = 1'b0;
        repeat (3) cycle();

        // T3: overflow with the consumer stalled.
        ready_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid_v = 1'b1; pc_v = 32'(i); instr_v = 32'(i) + 32'h2402_0000;
            cycle();
        end
        valid_v = 1'b0;
        cycle();
        chk("t3_level", 64'(bus.level), 64'd16);
        chk("t3_ovf", 64'(bus.ovf_cnt), 64'd4);

        // T4: push into a full FIFO while popping.
        valid_v = 1'b1; pc_v = 32'd100; instr_v = 32'h2402_0064; ready_v = 1'b1;
        cycle();
        chk("t4_level", 64'(bus.level), 64'd16);
        chk("t4_ovf", 64'(bus.ovf_cnt), 64'd4);
        chk("t4_head", 64'(bus.out_pc), 64'd1);
        valid_v = 1'b0;
        repeat (18) cycle();

        // T5: frozen pushes, then random traffic with backpressure.
        freeze_v = 1'b1; ready_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_v = 1'b1; pc_v = 32'(200 + i); instr_v = $urandom;
            cycle();
        end
        chk("t5_frozen_level", 64'(bus.level), 64'd0);
        freeze_v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            valid_v  = 1'($urandom % 2);
            ready_v  = 1'($urandom % 2);
            freeze_v = ($urandom % 8) == 0;
            pc_v     = $urandom;
            instr_v  = $urandom;
            cycle();
        end

        // Overflow counter saturation.
        freeze_v = 1'b0; ready_v = 1'b0; valid_v = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pc_v = $urandom;
            cycle();
        end
        chk("ovf_sat", 64'(bus.ovf_cnt), 64'd255);

        // Reset in mid-operation.
        rst = 1'b1;
        cycle();
        rst = 1'b0; valid_v = 1'b0;
        cycle();
        chk("midrst_level", 64'(bus.level), 64'd0);
        chk("midrst_ovf", 64'(bus.ovf_cnt), 64'd0);

`ifdef SM_TRACE_TRIGGER_EN
        // T6: capture begins at the trigger PC.
        trig_v = 32'd3; ready_v = 1'b0;
        for (int i = 0; i < 7; i++) begin
            valid_v = 1'b1; pc_v = 32'(i); instr_v = 32'(i) + 32'h2402_0000;
            cycle();
            if (i == 2) chk("t6_pre_armed", 64'(bus.armed), 64'd0);
        end
        valid_v = 1'b0;
        cycle();
        chk("t6_armed", 64'(bus.armed), 64'd1);
        chk("t6_level", 64'(bus.level), 64'd4);
        chk("t6_head", 64'(bus.out_pc), 64'd3);
        ready_v = 1'b1;
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        chk("t6_rst_armed", 64'(bus.armed), 64'd0);
        rst = 1'b0;
        cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
